// File: rtl/p_i_cache_lookup.sv
// Stage-2 instruction cache lookup: direct-mapped, flop-based arrays, miss stalls and fills a 256-bit line.
// Optional hit/miss performance counters are built when P_I_CACHE_PERF_EN is defined.
module p_i_cache_lookup #(
    parameter int NUM_SETS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s2_valid,
    input  logic [31:0]  s2_addr,
    output logic         imem_resp,
    output logic [31:0]  imem_rdata,
    output logic         stall,
    output logic         pmem_read,
    output logic [31:0]  pmem_address,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
`ifdef P_I_CACHE_PERF_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 32 - 5 - IDX_W;

    typedef enum logic {
        LOOKUP = 1'b0,
        FETCH  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [255:0]        data_q [NUM_SETS];

    // Only the line part of the miss address is kept; the offset is always zero.
    logic [26:0]      miss_line_q;
    logic [IDX_W-1:0] s2_idx;
    logic [TAG_W-1:0] s2_tag;
    logic [2:0]       s2_word;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;
    logic             hit;
    logic             load_miss;
    logic             fill;
    logic             unused_addr_bits;

    assign s2_idx   = s2_addr[5 +: IDX_W];
    assign s2_tag   = s2_addr[31 -: TAG_W];
    assign s2_word  = s2_addr[4:2];
    assign miss_idx = miss_line_q[IDX_W-1:0];
    assign miss_tag = miss_line_q[26 -: TAG_W];
    assign unused_addr_bits = ^s2_addr[1:0];

    assign hit        = s2_valid && valid_q[s2_idx] && (tag_q[s2_idx] == s2_tag)
                        && (state_q == LOOKUP);
    assign imem_rdata = data_q[s2_idx][{s2_word, 5'b0} +: 32];
    assign stall      = s2_valid && !imem_resp;

    always_comb begin
        state_d      = state_q;
        imem_resp    = 1'b0;
        pmem_read    = 1'b0;
        pmem_address = 32'd0;
        load_miss    = 1'b0;
        fill         = 1'b0;
        case (state_q)
            LOOKUP: begin
                imem_resp = hit;
                if (s2_valid && !hit) begin
                    load_miss = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_line_q, 5'b0};
                if (pmem_resp) begin
                    fill    = 1'b1;
                    state_d = LOOKUP;
                end
            end
            default: state_d = LOOKUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOOKUP;
            valid_q     <= '0;
            miss_line_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_miss) miss_line_q <= s2_addr[31:5];
            if (fill)      valid_q[miss_idx] <= 1'b1;
        end
    end

    // Tag and data contents are qualified by valid_q, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill && !rst) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= pmem_rdata;
        end
    end

`ifdef P_I_CACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (imem_resp) hit_count  <= hit_count + 32'd1;
            if (load_miss) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
